// File: rtl/mem_bus_router.sv
// Single-master address router: decodes the CPU address onto one of NUM_SLAVES ports.
// Optional access timeout enabled by defining MEM_BUS_ROUTER_TIMEOUT_EN.
module mem_bus_router #(
  parameter int                         NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {32'h8000_0000, 32'h2000_0000,
                                                          32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {32'hF000_0000, 32'hFF00_0000,
                                                          32'hFFFF_FF00, 32'hFFFF_0000},
  parameter int                         TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cpu_valid,
  input  logic [31:0]                cpu_addr,
  input  logic [3:0]                 cpu_wstrb,
  input  logic [31:0]                cpu_wdata,
  output logic [31:0]                cpu_rdata,
  output logic                       cpu_ready,
  output logic                       cpu_fault,
  output logic [NUM_SLAVES-1:0]      s_valid,
  output logic [31:0]                s_addr,
  output logic [3:0]                 s_wstrb,
  output logic [31:0]                s_wdata,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [31:0]                fault_addr,
  output logic [7:0]                 fault_cnt
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic                    fault_q, fault_d;
  logic [31:0]             fault_addr_q, fault_addr_d;
  logic [7:0]              fault_cnt_q, fault_cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [31:0]             addr_q, addr_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    hit;
  logic [SEL_W-1:0]        hit_idx;
  logic [NUM_SLAVES-1:0]   hit_onehot;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic [7:0]              fault_cnt_inc;

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;
  logic [15:0]             tmo_next;
  assign tmo_next = tmo_cnt_q + 16'd1;
`endif

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit        = 1'b1;
        hit_idx    = SEL_W'(i);
        hit_onehot = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  assign fault_cnt_inc = (fault_cnt_q == 8'hFF) ? fault_cnt_q : fault_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    s_valid_d    = s_valid_q;
    cpu_ready_d  = 1'b0;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    fault_cnt_d  = fault_cnt_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      // cpu_ready_q high means the CPU is still holding the request just answered.
      IDLE: begin
        if (cpu_valid && !cpu_ready_q) begin
          addr_d = cpu_addr;
          if (hit) begin
            sel_d     = hit_idx;
            wstrb_d   = cpu_wstrb;
            wdata_d   = cpu_wdata;
            s_valid_d = hit_onehot;
            state_d   = ACCESS;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            fault_d      = 1'b1;
            rdata_d      = '0;
            fault_addr_d = cpu_addr;
            fault_cnt_d  = fault_cnt_inc;
            state_d      = RESP;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_d   = sel_rdata;
          fault_d   = 1'b0;
          s_valid_d = '0;
          state_d   = RESP;
        end
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
        else begin
          tmo_cnt_d = tmo_next;
          if (tmo_next == 16'(TIMEOUT_CYCLES)) begin
            s_valid_d    = '0;
            fault_d      = 1'b1;
            rdata_d      = '0;
            fault_addr_d = addr_q;
            fault_cnt_d  = fault_cnt_inc;
            state_d      = RESP;
          end
        end
`endif
      end
      RESP: begin
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      s_valid_q    <= '0;
      cpu_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      s_valid_q    <= s_valid_d;
      cpu_ready_q  <= cpu_ready_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      fault_cnt_q  <= fault_cnt_d;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    sel_q   <= sel_d;
    addr_q  <= addr_d;
    wstrb_q <= wstrb_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign s_valid    = s_valid_q;
  assign s_addr     = addr_q;
  assign s_wstrb    = wstrb_q;
  assign s_wdata    = wdata_q;
  assign cpu_ready  = cpu_ready_q;
  assign cpu_rdata  = cpu_ready_q ? rdata_q : 32'd0;
  assign cpu_fault  = cpu_ready_q & fault_q;
  assign fault_addr = fault_addr_q;
  assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Directed bench for mem_bus_router; exercises the timeout path when
// MEM_BUS_ROUTER_TIMEOUT_EN is defined.
module tb_mem_bus_router;

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         cpu_valid;
  logic [31:0]  cpu_addr;
  logic [3:0]   cpu_wstrb;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         cpu_fault;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;
  logic [31:0]  fault_addr;
  logic [7:0]   fault_cnt;

  int vectors = 0;
  int errors  = 0;
  int exp_cnt = 0;

  mem_bus_router #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wstrb(cpu_wstrb),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_fault(cpu_fault),
    .s_valid(s_valid), .s_addr(s_addr), .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .fault_addr(fault_addr), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave idx readies on its first s_valid cycle; checks the 3-cycle latency.
  task automatic fast_access(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic [31:0] wdata, input int idx, input logic [31:0] rd);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    cpu_addr = addr; cpu_wstrb = wstrb; cpu_wdata = wdata; cpu_valid = 1'b1;
    tick();
    check({tag, "_svalid"}, {28'd0, s_valid}, {28'd0, oh});
    check({tag, "_saddr"}, s_addr, addr);
    check({tag, "_rdy_c1"}, {31'd0, cpu_ready}, 32'd0);
    s_ready = oh;
    s_rdata = '0;
    s_rdata[idx*32 +: 32] = rd;
    tick();
    check({tag, "_svalid_drop"}, {28'd0, s_valid}, 32'd0);
    check({tag, "_rdy_c2"}, {31'd0, cpu_ready}, 32'd0);
    s_ready = 4'b0000;
    tick();
    check({tag, "_rdy"}, {31'd0, cpu_ready}, 32'd1);
    check({tag, "_rdata"}, cpu_rdata, rd);
    check({tag, "_fault"}, {31'd0, cpu_fault}, 32'd0);
    cpu_valid = 1'b0;
    tick();
    check({tag, "_rdy_clr"}, {31'd0, cpu_ready}, 32'd0);
    check({tag, "_rdata_clr"}, cpu_rdata, 32'd0);
    check({tag, "_no_retrig"}, {28'd0, s_valid}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; cpu_valid = 1'b1; cpu_addr = 32'h5000_0000;
    cpu_wstrb = 4'b0000; cpu_wdata = '0; s_rdata = '0; s_ready = 4'b1111;

    // Reset with a live unmapped request: nothing may move.
    tick(); tick(); tick();
    check("rst_svalid", {28'd0, s_valid}, 32'd0);
    check("rst_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_fault", {31'd0, cpu_fault}, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_faddr", fault_addr, 32'd0);
    check("rst_fcnt", {24'd0, fault_cnt}, 32'd0);
    cpu_valid = 1'b0; s_ready = 4'b0000;
    resetn = 1'b1;
    tick();

    fast_access("rd1", 32'h1000_0004, 4'b0000, 32'd0, 1, 32'hCAFE_F00D);

    // Write to slave 0 while other slaves shout ready; they must be ignored.
    cpu_addr = 32'h0000_0010; cpu_wstrb = 4'b0011; cpu_wdata = 32'h1234_5678; cpu_valid = 1'b1;
    tick();
    check("wr_svalid", {28'd0, s_valid}, 32'h1);
    check("wr_swstrb", {28'd0, s_wstrb}, 32'h3);
    check("wr_swdata", s_wdata, 32'h1234_5678);
    s_ready = 4'b1110;
    s_rdata = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    tick();
    check("wr_ignore_other", {28'd0, s_valid}, 32'h1);
    check("wr_ignore_rdy", {31'd0, cpu_ready}, 32'd0);
    s_ready = 4'b0001;
    tick();
    check("wr_svalid_drop", {28'd0, s_valid}, 32'd0);
    s_ready = 4'b0000;
    tick();
    check("wr_rdy", {31'd0, cpu_ready}, 32'd1);
    check("wr_fault", {31'd0, cpu_fault}, 32'd0);
    cpu_valid = 1'b0;
    tick();

    // Unmapped read: 2-cycle fault response.
    cpu_addr = 32'h5000_0000; cpu_wstrb = 4'b0000; cpu_valid = 1'b1;
    tick();
    check("um_svalid", {28'd0, s_valid}, 32'd0);
    check("um_rdy_c1", {31'd0, cpu_ready}, 32'd0);
    check("um_faddr", fault_addr, 32'h5000_0000);
    check("um_fcnt", {24'd0, fault_cnt}, 32'd1);
    tick();
    check("um_rdy", {31'd0, cpu_ready}, 32'd1);
    check("um_fault", {31'd0, cpu_fault}, 32'd1);
    check("um_rdata", cpu_rdata, 32'd0);
    cpu_valid = 1'b0;
    tick();
    check("um_svalid_after", {28'd0, s_valid}, 32'd0);

    // Reset while in ACCESS on slave 2.
    cpu_addr = 32'h2000_0040; cpu_valid = 1'b1;
    tick();
    check("ra_svalid", {28'd0, s_valid}, 32'h4);
    resetn = 1'b0; cpu_valid = 1'b0;
    tick();
    check("ra_svalid_clr", {28'd0, s_valid}, 32'd0);
    check("ra_rdy", {31'd0, cpu_ready}, 32'd0);
    check("ra_fcnt", {24'd0, fault_cnt}, 32'd0);
    check("ra_faddr", fault_addr, 32'd0);
    resetn = 1'b1;
    s_ready = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ra_no_ready", {31'd0, cpu_ready}, 32'd0);
      check("ra_idle_svalid", {28'd0, s_valid}, 32'd0);
    end
    s_ready = 4'b0000;
    fast_access("post_rst", 32'h0000_0020, 4'b0000, 32'd0, 0, 32'h0BAD_BEEF);

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
    // Slave 3 never answers: fault after TMO waiting cycles.
    cpu_addr = 32'h8000_0000; cpu_valid = 1'b1;
    tick();
    for (int i = 1; i < TMO; i++) tick();
    check("to_svalid_held", {28'd0, s_valid}, 32'h8);
    check("to_rdy_early", {31'd0, cpu_ready}, 32'd0);
    tick();
    check("to_svalid_drop", {28'd0, s_valid}, 32'd0);
    tick();
    check("to_rdy", {31'd0, cpu_ready}, 32'd1);
    check("to_fault", {31'd0, cpu_fault}, 32'd1);
    check("to_rdata", cpu_rdata, 32'd0);
    check("to_faddr", fault_addr, 32'h8000_0000);
    check("to_fcnt", {24'd0, fault_cnt}, 32'd1);
    cpu_valid = 1'b0;
    tick();
    check("to_svalid_after", {28'd0, s_valid}, 32'd0);
    exp_cnt = 1;
`else
    // Without the timeout the router waits as long as the slave takes.
    cpu_addr = 32'h8000_0000; cpu_valid = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) tick();
    check("wait_svalid_held", {28'd0, s_valid}, 32'h8);
    check("wait_no_rdy", {31'd0, cpu_ready}, 32'd0);
    s_ready = 4'b1000; s_rdata = '0; s_rdata[96 +: 32] = 32'hA5A5_0001;
    tick();
    s_ready = 4'b0000;
    tick();
    check("wait_rdy", {31'd0, cpu_ready}, 32'd1);
    check("wait_rdata", cpu_rdata, 32'hA5A5_0001);
    check("wait_fault", {31'd0, cpu_fault}, 32'd0);
    cpu_valid = 1'b0;
    tick();
    exp_cnt = 0;
`endif

    // Fault counter saturation.
    for (int n = 0; n < 300; n++) begin
      int budget;
      cpu_addr = 32'h5000_0000 + 32'(n * 4); cpu_valid = 1'b1;
      budget = 0;
      tick();
      while (!cpu_ready && budget < 6) begin
        tick();
        budget++;
      end
      if (!cpu_ready) check("sat_timeout", {31'd0, cpu_ready}, 32'd1);
      cpu_valid = 1'b0;
      tick();
      if (exp_cnt < 255) exp_cnt++;
      if (n == 99) check("sat_mid", {24'd0, fault_cnt}, 32'(exp_cnt));
    end
    check("sat_fcnt", {24'd0, fault_cnt}, 32'd255);
    check("sat_faddr", fault_addr, 32'h5000_0000 + 32'(299 * 4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
